// File: rtl/bus_arbiter_nm.sv
// bus_arbiter_nm: N-master to 1-slave arbiter for the req/we/addr/be/wdata/
// ack/resp/rdata memory bus. Holds the grant on a master across ack-stall and
// routes in-order read responses back through an owner-ID FIFO.
// Optional feature: define BUS_ARB_ROUND_ROBIN_EN for round-robin priority;
// without it, fixed priority (lowest index wins) and no pointer register.
module bus_arbiter_nm #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int RD_DEPTH  = 4
) (
  input  logic                              clk_i,
  input  logic                              arst_n_i,
  input  logic [N_MASTERS-1:0]              m_req_i,
  input  logic [N_MASTERS-1:0]              m_we_i,
  input  logic [N_MASTERS*ADDR_W-1:0]       m_addr_bi,
  input  logic [N_MASTERS*DATA_W/8-1:0]     m_be_bi,
  input  logic [N_MASTERS*DATA_W-1:0]       m_wdata_bi,
  output logic [N_MASTERS-1:0]              m_ack_o,
  output logic [N_MASTERS-1:0]              m_resp_o,
  output logic [N_MASTERS*DATA_W-1:0]       m_rdata_bo,
  output logic                              s_req_o,
  output logic                              s_we_o,
  output logic [ADDR_W-1:0]                 s_addr_bo,
  output logic [DATA_W/8-1:0]               s_be_bo,
  output logic [DATA_W-1:0]                 s_wdata_bo,
  input  logic                              s_ack_i,
  input  logic                              s_resp_i,
  input  logic [DATA_W-1:0]                 s_rdata_bi,
  output logic [$clog2(RD_DEPTH+1)-1:0]     rd_pending_bo,
  output logic                              spurious_resp_o
);

  localparam int BE_W  = DATA_W / 8;
  localparam int ID_W  = $clog2(N_MASTERS);
  localparam int PTR_W = $clog2(RD_DEPTH);
  localparam int CNT_W = $clog2(RD_DEPTH + 1);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RD_DEPTH);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_MASTERS - 1);

  localparam logic [0:0] ST_UNLOCKED = 1'b0;
  localparam logic [0:0] ST_LOCKED   = 1'b1;

  logic [0:0]       r_state;
  logic [ID_W-1:0]  r_lock_id;
  logic [ID_W-1:0]  r_fifo [RD_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_spurious;
`ifdef BUS_ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0]  r_rr_ptr;
`endif

  logic [N_MASTERS-1:0] w_elig;
  logic                 w_pick_vld;
  logic [ID_W-1:0]      w_pick;
  logic                 w_gnt;
  logic [ID_W-1:0]      w_owner;
  logic [ID_W-1:0]      w_head;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;

  // A read is only eligible while the registered count shows a free FIFO slot.
  assign w_elig = m_req_i & (m_we_i | {N_MASTERS{r_count != FULL_CNT}});

  // Priority search over eligible masters, starting at the RR pointer or at 0.
  always_comb begin
    int idx;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    idx        = 0;
    w_pick_vld = 1'b0;
    w_pick     = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
      idx = int'(r_rr_ptr) + i;
      if (idx >= N_MASTERS) idx = idx - N_MASTERS;
`else
      idx = i;
`endif
      if (!w_pick_vld && w_elig[idx]) begin
        w_pick_vld = 1'b1;
        w_pick     = ID_W'(idx);
      end
    end
  end

  // A locked owner keeps the bus; it stays eligible because the count cannot grow meanwhile.
  assign w_owner = (r_state == ST_LOCKED) ? r_lock_id : w_pick;
  assign w_gnt   = (r_state == ST_LOCKED) ? m_req_i[r_lock_id] : w_pick_vld;
  assign w_head  = r_fifo[r_rd_ptr];

  assign w_accept = w_gnt & s_ack_i;
  assign w_push   = w_accept & ~m_we_i[w_owner];
  assign w_pop    = s_resp_i & (r_count != '0);

  // Request mux toward the slave and per-master ack fan-out; payload is zero when idle.
  always_comb begin
    s_req_o    = 1'b0;
    s_we_o     = 1'b0;
    s_addr_bo  = '0;
    s_be_bo    = '0;
    s_wdata_bo = '0;
    m_ack_o    = '0;
    if (w_gnt) begin
      s_req_o            = 1'b1;
      s_we_o             = m_we_i[w_owner];
      s_addr_bo          = m_addr_bi[int'(w_owner)*ADDR_W +: ADDR_W];
      s_be_bo            = m_be_bi[int'(w_owner)*BE_W +: BE_W];
      s_wdata_bo         = m_wdata_bi[int'(w_owner)*DATA_W +: DATA_W];
      m_ack_o[w_owner]   = s_ack_i;
    end
  end

  // Read response routing to the master at the head of the ID FIFO.
  always_comb begin
    m_resp_o   = '0;
    m_rdata_bo = '0;
    if (w_pop) begin
      m_resp_o[w_head]                           = 1'b1;
      m_rdata_bo[int'(w_head)*DATA_W +: DATA_W]  = s_rdata_bi;
    end
  end

  // Lock FSM: hold the owner while the slave stalls its ack.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!arst_n_i) begin
      r_state   <= ST_UNLOCKED;
      r_lock_id <= '0;
    end else begin
      case (r_state)
        ST_UNLOCKED: if (w_gnt && !s_ack_i) begin
          r_state   <= ST_LOCKED;
          r_lock_id <= w_owner;
        end
        default:     if (s_ack_i) r_state <= ST_UNLOCKED;
      endcase
    end
  end

  // ID FIFO storage.
  always_ff @(posedge clk_i) begin
    // NOTE: storage is not reset; entries are only read behind a non-zero count, which is reset.
    if (w_push) r_fifo[r_wr_ptr] <= w_owner;
  end

  // FIFO pointers and exact outstanding-read count; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky flag for a slave response arriving with no read outstanding.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i)                    r_spurious <= 1'b0;
    else if (s_resp_i && !w_pop)      r_spurious <= 1'b1;
  end

`ifdef BUS_ARB_ROUND_ROBIN_EN
  // Round-robin pointer moves past the owner on every accepted request.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i)     r_rr_ptr <= '0;
    else if (w_accept) r_rr_ptr <= (w_owner == LAST_ID) ? '0 : w_owner + 1'b1;
  end
`else
  logic w_unused_last;
  assign w_unused_last = |LAST_ID;
`endif

  assign rd_pending_bo   = r_count;
  assign spurious_resp_o = r_spurious;

endmodule

// File: tb/tb_bus_arbiter_nm.sv
// Directed bench for bus_arbiter_nm (N=2, 32-bit, RD_DEPTH=4) with a read
// response scoreboard. Expected grants follow BUS_ARB_ROUND_ROBIN_EN if defined.
module tb_bus_arbiter_nm;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic [1:0]  m_req = '0;
  logic [1:0]  m_we = '0;
  logic [63:0] m_addr = '0;
  logic [7:0]  m_be = '0;
  logic [63:0] m_wdata = '0;
  logic [1:0]  m_ack_o, m_resp_o;
  logic [63:0] m_rdata_bo;
  logic        s_req_o, s_we_o;
  logic [31:0] s_addr_bo, s_wdata_bo;
  logic [3:0]  s_be_bo;
  logic        s_ack = 1'b0;
  logic        s_resp = 1'b0;
  logic [31:0] s_rdata = '0;
  logic [2:0]  rd_pending_bo;
  logic        spurious_resp_o;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          id;
    logic [31:0] data;
  } rd_exp_t;

  rd_exp_t     sb[$];     // expected read responses, in issue order
  logic [31:0] slv_q[$];  // slave model: addresses of accepted reads

  bus_arbiter_nm dut (
    .clk_i(clk), .arst_n_i(arst_n),
    .m_req_i(m_req), .m_we_i(m_we), .m_addr_bi(m_addr), .m_be_bi(m_be),
    .m_wdata_bi(m_wdata), .m_ack_o(m_ack_o), .m_resp_o(m_resp_o),
    .m_rdata_bo(m_rdata_bo), .s_req_o(s_req_o), .s_we_o(s_we_o),
    .s_addr_bo(s_addr_bo), .s_be_bo(s_be_bo), .s_wdata_bo(s_wdata_bo),
    .s_ack_i(s_ack), .s_resp_i(s_resp), .s_rdata_bi(s_rdata),
    .rd_pending_bo(rd_pending_bo), .spurious_resp_o(spurious_resp_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] mem_f(logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave model records the address of every read it accepts.
  always @(negedge clk)
    if (arst_n && s_req_o && s_ack && !s_we_o) slv_q.push_back(s_addr_bo);

  // Slave drives a response for the oldest accepted read (or garbage if none).
  task automatic set_resp(bit on);
    s_resp = on;
    if (on) s_rdata = (slv_q.size() > 0) ? mem_f(slv_q.pop_front()) : 32'hDEAD_BEEF;
    else    s_rdata = '0;
  endtask

  // One bus cycle: own >= 0 expects that master on the slave port, -2 expects an idle port.
  task automatic cycle(string tag, logic [1:0] exp_ack, int own);
    rd_exp_t e;
    int      id;
    @(negedge clk);
    check({tag, "/ack"}, 64'(m_ack_o), 64'(exp_ack));
    if (own >= 0) begin
      check({tag, "/sreq"}, 64'(s_req_o), 64'd1);
      check({tag, "/saddr"}, 64'(s_addr_bo), 64'(m_addr[own*32 +: 32]));
    end else if (own == -2) begin
      check({tag, "/idle"}, {31'd0, s_req_o, s_addr_bo}, 64'd0);
    end
    if (s_resp) begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({tag, "/resp"}, 64'(m_resp_o), 64'd1 << e.id);
        check({tag, "/rdata"}, 64'(m_rdata_bo[e.id*32 +: 32]), 64'(e.data));
        check({tag, "/rdata_other"}, 64'(m_rdata_bo[(1-e.id)*32 +: 32]), 64'd0);
      end else begin
        check({tag, "/noresp"}, 64'(m_resp_o), 64'd0);
      end
    end
    if (exp_ack != 2'b00) begin
      id = exp_ack[1] ? 1 : 0;
      if (!m_we[id]) sb.push_back('{id, mem_f(m_addr[id*32 +: 32])});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp;

    // Reset state
    #12;
    check("rst/pend", 64'(rd_pending_bo), 64'd0);
    check("rst/spur", 64'(spurious_resp_o), 64'd0);
    check("rst/outs", {58'd0, m_ack_o, m_resp_o, s_req_o, s_we_o}, 64'd0);
    @(negedge clk); arst_n = 1'b1;
    @(posedge clk); #1;

    // Both masters read every cycle, ack=1, responses two cycles later
    m_addr = {32'h0000_0200, 32'h0000_0100};
    m_we   = 2'b00;
    s_ack  = 1'b1;
    for (int c = 0; c < 8; c++) begin
      m_req = (c < 6) ? 2'b11 : 2'b00;
      set_resp(c >= 2);
`ifdef BUS_ARB_ROUND_ROBIN_EN
      exp = (c < 6) ? ((c % 2) ? 2'b10 : 2'b01) : 2'b00;
`else
      exp = (c < 6) ? 2'b01 : 2'b00;
`endif
      cycle("t1", exp, -1);
    end
    set_resp(0);
    check("t1/pend", 64'(rd_pending_bo), 64'd0);

    // Lock: master 1 stalled three cycles, master 0 arrives meanwhile
    m_addr = {32'h0000_0300, 32'h0000_0400};
    s_ack = 1'b0; m_req = 2'b10;
    cycle("t2a", 2'b00, 1);
    m_req = 2'b11;
    cycle("t2b", 2'b00, 1);
    cycle("t2c", 2'b00, 1);
    s_ack = 1'b1;
    cycle("t2d", 2'b10, 1);
    m_req = 2'b01;
    cycle("t2e", 2'b01, 0);
    m_req = 2'b00;
    set_resp(1); cycle("t2f", 2'b00, -2);
    set_resp(1); cycle("t2g", 2'b00, -2);
    set_resp(0);
    check("t2/pend", 64'(rd_pending_bo), 64'd0);

    // Full FIFO: fifth read held off while the other master's write goes through
    m_req = 2'b01; m_we = 2'b00; s_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_addr[31:0] = 32'h10 + 32'(4 * i);
      cycle("t3fill", 2'b01, 0);
    end
    check("t3/pend_full", 64'(rd_pending_bo), 64'd4);
    m_addr = {32'h0000_0900, 32'h0000_0020};
    m_wdata = {32'hCAFE_F00D, 32'h0};
    m_be = 8'hF0;
    m_we = 2'b10; m_req = 2'b11;
    #1;
    check("t3/wr_we", 64'(s_we_o), 64'd1);
    check("t3/wr_data", {28'd0, s_be_bo, s_wdata_bo}, {28'd0, 4'hF, 32'hCAFE_F00D});
    cycle("t3wr", 2'b10, 1);
    m_req = 2'b01; m_we = 2'b00;
    set_resp(1); cycle("t3blk", 2'b00, -2);
    set_resp(0); cycle("t3unblk", 2'b01, 0);
    check("t3/pend_refill", 64'(rd_pending_bo), 64'd4);
    m_req = 2'b00;
    for (int i = 0; i < 4; i++) begin
      set_resp(1); cycle("t3drain", 2'b00, -2);
    end
    set_resp(0);
    check("t3/pend", 64'(rd_pending_bo), 64'd0);

    // Response and new read accept in the same cycle at count 2
    m_req = 2'b10; m_addr[63:32] = 32'h500;
    cycle("t4a", 2'b10, 1);
    m_addr[63:32] = 32'h504;
    cycle("t4b", 2'b10, 1);
    check("t4/pend2", 64'(rd_pending_bo), 64'd2);
    m_req = 2'b01; m_addr[31:0] = 32'h600;
    set_resp(1); cycle("t4c", 2'b01, 0);
    check("t4/pend_same", 64'(rd_pending_bo), 64'd2);
    m_req = 2'b00;
    set_resp(1); cycle("t4d", 2'b00, -2);
    set_resp(1); cycle("t4e", 2'b00, -2);
    set_resp(0);
    check("t4/pend", 64'(rd_pending_bo), 64'd0);

    // Spurious response with nothing pending
    set_resp(1); cycle("t5spur", 2'b00, -2);
    set_resp(0);
    check("t5/spur_set", 64'(spurious_resp_o), 64'd1);

    // Reset in the middle of a locked burst
    m_req = 2'b10; m_addr[63:32] = 32'h700; s_ack = 1'b1;
    cycle("t5a", 2'b10, 1);
    m_addr[63:32] = 32'h704;
    cycle("t5b", 2'b10, 1);
    check("t5/pend2", 64'(rd_pending_bo), 64'd2);
    s_ack = 1'b0; m_addr[63:32] = 32'h708;
    cycle("t5lock", 2'b00, 1);
    m_req = 2'b11; m_we = 2'b01; m_addr[31:0] = 32'h800;
    #1;
    check("t5/locked_addr", 64'(s_addr_bo), 64'h708);
    #2; arst_n = 1'b0; #1;
    check("t5/rst_pend", 64'(rd_pending_bo), 64'd0);
    check("t5/rst_spur", 64'(spurious_resp_o), 64'd0);
    check("t5/rst_unlock", 64'(s_addr_bo), 64'h800);
    sb.delete();
    slv_q.delete();
    @(negedge clk); arst_n = 1'b1;
    @(posedge clk); #1;
    s_ack = 1'b1;
    cycle("t5post", 2'b01, 0);
    m_req = 2'b00; m_we = 2'b00; s_ack = 1'b0;
    set_resp(1); cycle("t5stale", 2'b00, -2);
    set_resp(0);
    check("t5/stale_spur", 64'(spurious_resp_o), 64'd1);
    check("t5/stale_pend", 64'(rd_pending_bo), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_nm.md
# bus_arbiter_nm

Parametrised N-master to 1-slave arbiter for the req/we/addr/be/wdata/ack/resp/rdata memory bus. It generalises the fixed two-master data-port mux used in the memsplit subsystem: configurable master count and widths, grant locking across ack-stall, in-order tracking of up to RD_DEPTH outstanding reads, and selectable fixed or round-robin priority. It sits between the debug/CPU data masters and a bus unit slave port.

## Interface
- N_MASTERS, 2, number of masters (2..8); index 0 is highest fixed priority
- ADDR_W, 32, address width
- DATA_W, 32, data width (multiple of 8); byte enables are DATA_W/8 bits
- RD_DEPTH, 4, max outstanding reads (power of 2, 2..16)
- clk_i  in  1  clock
- arst_n_i  in  1  reset, asynchronous, active-low
- m_req_i  in  N_MASTERS  per-master request
- m_we_i  in  N_MASTERS  per-master write enable
- m_addr_bi  in  N_MASTERS*ADDR_W  packed addresses, master k at [k*ADDR_W +: ADDR_W]
- m_be_bi  in  N_MASTERS*DATA_W/8  packed byte enables
- m_wdata_bi  in  N_MASTERS*DATA_W  packed write data
- m_ack_o  out  N_MASTERS  per-master request accept
- m_resp_o  out  N_MASTERS  per-master read response valid
- m_rdata_bo  out  N_MASTERS*DATA_W  packed read data
- s_req_o, s_we_o  out  1 each  slave request, write enable
- s_addr_bo  out  ADDR_W; s_be_bo  out  DATA_W/8; s_wdata_bo  out  DATA_W
- s_ack_i, s_resp_i  in  1 each  slave accept, slave read response
- s_rdata_bi  in  DATA_W  slave read data
- rd_pending_bo  out  $clog2(RD_DEPTH+1)  outstanding read count
- spurious_resp_o  out  1  sticky: s_resp_i seen with no read outstanding

## Operation
- Masters hold req and payload stable until ack; slave returns read responses in acceptance order, ≥1 cycle after ack; writes get no response.
- Eligible master: m_req_i=1 and (m_we_i=1 or rd count < RD_DEPTH).
- State UNLOCKED: owner chosen combinationally among eligible masters by priority; its payload drives s_*, s_req_o=1. If s_ack_i=0, go LOCKED(owner).
- State LOCKED(k): owner k forced regardless of other requests, even if its read became ineligible? No: lock is only taken for eligible requests and count cannot grow while locked, so k stays eligible. On s_ack_i=1 return to UNLOCKED.
- m_ack_o[k] = s_ack_i when k is owner, else 0. Non-owners see all outputs 0 for their slot except responses.
- On read accept (s_req_o & ~s_we_o & s_ack_i) push owner ID into ID FIFO (depth RD_DEPTH).
- On s_resp_i with FIFO non-empty: pop head ID h; m_resp_o[h]=1, m_rdata_bo slot h = s_rdata_bi, other slots 0. Push and pop in one cycle: both performed, count unchanged.
- s_resp_i with FIFO empty: dropped, spurious_resp_o set until reset.
- Counter and FIFO pointers wrap modulo RD_DEPTH; count is exact 0..RD_DEPTH.
- Unused s_* payload outputs are 0 when s_req_o=0.

## Timing
- Reset (arst_n_i=0, asynchronous): state UNLOCKED, FIFO empty, rd_pending_bo=0, spurious_resp_o=0, priority pointer 0; all m_ack_o/m_resp_o/s_req_o combinationally 0 given no req/resp. Responses for reads issued before reset are spurious afterwards.
- Request path combinational: m_req_i to s_req_o, s_ack_i to m_ack_o, zero latency; s_resp_i to m_resp_o zero latency.
- Full condition uses registered count: a resp popping in cycle t does not unblock a read until t+1.
- Lock and pointer update take effect the cycle after the event.

## Configuration
- BUS_ARB_ROUND_ROBIN_EN defined: round-robin; pointer p updates to (owner+1) mod N_MASTERS on every accept; search starts at p.
- Undefined: fixed priority, lowest index wins; no pointer register.

## Test plan
- N=2, both masters read every cycle, slave ack=1, resp 2 cycles later: fixed mode master 0 starves master 1; RR mode grants alternate 0,1,0,1 and each m_resp_o matches its own address data.
- Master 1 requests, slave ack held 0 for 3 cycles, master 0 requests in cycle 2: grant stays on master 1 until its ack, then master 0.
- RD_DEPTH=4, slave delays all resps: 4 reads accepted, rd_pending_bo=4, 5th read held off while a write from other master is accepted; first resp unblocks read next cycle.
- Resp and new read accept same cycle at count 2: count stays 2, correct master receives data.
- s_resp_i pulse with nothing pending -> spurious_resp_o=1, no m_resp_o; arst_n_i low mid-burst -> count 0, flag cleared, lock released.
